// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control blocks (hazard/stall
// unit and forwarding unit): instruction field layout, opcode constants,
// the bubble instruction, the stall-controller action/state encoding and
// the decoded-instruction / shadow-scoreboard record types.
package pipe_pkg;

    localparam int INSTR_W = 19;

    // Instruction field slices: [18:14] op, [13:11] dst, [10:8] A, [7:5] B.
    // Bits [4:0] are not interpreted by the pipeline control.
    localparam int OP_MSB  = 18;
    localparam int OP_LSB  = 14;
    localparam int DST_MSB = 13;
    localparam int DST_LSB = 11;
    localparam int A_MSB   = 10;
    localparam int A_LSB   = 8;
    localparam int B_MSB   = 7;
    localparam int B_LSB   = 5;

    localparam logic [4:0] OP_LW = 5'b10000;
    localparam logic [4:0] OP_SW = 5'b10001;

    // Bubble: an ALU op writing r0, so it can never be a producer.
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic       is_alu;
        logic       is_imm;
        logic       is_lw;
        logic       is_sw;
        logic [2:0] dst;
        logic [2:0] a;
        logic [2:0] b;
    } decoded_t;

    // One shadow-scoreboard slot: what an in-flight instruction means to the
    // stall logic. For SW the dst field is store data, but is_lw=0 keeps it
    // from ever being treated as a producer.
    typedef struct packed {
        logic [2:0] dst;
        logic       is_lw;
        logic       is_mem;
    } sb_entry_t;

    function automatic decoded_t decode_instr(input logic [INSTR_W-1:0] instr);
        decoded_t   d;
        logic [4:0] op;
        op       = instr[OP_MSB:OP_LSB];
        d.is_alu = ~op[4];
        d.is_imm = op[3];
        d.is_lw  = (op == OP_LW);
        d.is_sw  = (op == OP_SW);
        d.dst    = instr[DST_MSB:DST_LSB];
        d.a      = instr[A_MSB:A_LSB];
        d.b      = instr[B_MSB:B_LSB];
        return d;
    endfunction

    function automatic sb_entry_t to_entry(input decoded_t d);
        sb_entry_t e;
        e.dst    = d.dst;
        e.is_lw  = d.is_lw;
        e.is_mem = d.is_lw | d.is_sw;
        return e;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Handshake bundle between the pipeline datapath and the hazard/stall unit.
//   master : datapath side  - drives IF_ID instruction/valid, branch and
//            memory status; receives the stall/flush controls.
//   slave  : hazard unit    - the reverse.
// STALL_CNT_W must match the STALL_CNT_W of the connected hazard_stall_unit.
interface hazard_stall_unit_if #(
    parameter int STALL_CNT_W = 16
);
    import pipe_pkg::*;

    logic [INSTR_W-1:0]     IF_ID_instruction;
    logic                   IF_ID_valid;
    logic                   branch_taken_EX;
    logic                   mem_ready;
    logic                   pc_write;
    logic                   IF_ID_write;
    logic                   IF_ID_flush;
    logic                   ID_EX_bubble;
    logic                   pipe_freeze;
    logic [1:0]             state;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output IF_ID_instruction, IF_ID_valid, branch_taken_EX, mem_ready,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze,
               state, stall_count
    );

    modport slave (
        input  IF_ID_instruction, IF_ID_valid, branch_taken_EX, mem_ready,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze,
               state, stall_count
    );

endinterface

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier.
//   i_instr : 19-bit instruction word
//   o_dec   : {is_alu, is_imm, is_lw, is_sw, dst, A, B}
module instr_class_decode
    import pipe_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output decoded_t           o_dec
);

    // Low bits carry nothing the control path cares about.
    logic w_unused_tail;
    assign w_unused_tail = ^i_instr[B_LSB-1:0];

    assign o_dec = decode_instr(i_instr);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline. Detects load-use,
// data-memory wait and taken-branch hazards using a private shadow copy of
// the ID_EX / EX_MEM destinations, and drives the PC/IF_ID enables, bubble
// insertion, flush and freeze.
//   clk, rst_n : pipeline clock, synchronous active-low reset
//   bus        : hazard_stall_unit_if.slave (IF_ID instruction + status in,
//                controls, registered action `state` and `stall_count` out)
module hazard_stall_unit
    import pipe_pkg::*;
#(
    parameter int                 STALL_CNT_W = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = pipe_pkg::NOP_INSTR
)(
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_unit_if.slave  bus
);

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);
    // Scoreboard image of the bubble actually loaded into ID_EX.
    localparam sb_entry_t NOP_ENTRY = to_entry(decode_instr(NOP_INSTR));

    sb_entry_t              r_sb_idex;
    sb_entry_t              r_sb_exmem;
    hz_state_e              r_state;
    logic [STALL_CNT_W-1:0] r_stall_count;

    decoded_t               w_dec;
    logic                   w_load_use;
    logic                   w_mem_wait;
    hz_state_e              w_action;
    logic                   w_pc_write;
    logic                   w_if_id_write;
    logic                   w_if_id_flush;
    logic                   w_id_ex_bubble;
    logic                   w_pipe_freeze;

    instr_class_decode u_decode (
        .i_instr (bus.IF_ID_instruction),
        .o_dec   (w_dec)
    );

    // Hazard detection and action selection. Memory wait outranks the branch
    // because a frozen EX stage keeps re-presenting the branch until it can
    // move; the branch in turn overrides a pending load-use stall. While
    // rst_n is low the pipeline must run freely regardless of stale state.
    always_comb begin
        w_mem_wait = r_sb_exmem.is_mem && !bus.mem_ready;
        // LW->SW store data (dst field) is covered by MEM forwarding, so only
        // the address (A) and, for register ALU ops, B can cause a stall.
        w_load_use = r_sb_idex.is_lw && (r_sb_idex.dst != 3'd0) && bus.IF_ID_valid &&
                     (((w_dec.is_alu || w_dec.is_lw || w_dec.is_sw) && (r_sb_idex.dst == w_dec.a)) ||
                      (w_dec.is_alu && !w_dec.is_imm && (r_sb_idex.dst == w_dec.b)));

        if (!rst_n)                    w_action = RUN;
        else if (w_mem_wait)           w_action = MEM_WAIT;
        else if (bus.branch_taken_EX)  w_action = FLUSH;
        else if (w_load_use)           w_action = LOAD_STALL;
        else                           w_action = RUN;
    end

    always_comb begin
        // NOTE: every output of this block is given a default before the case,
        // so no path leaves one unassigned and no latch is inferred.
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_pipe_freeze  = 1'b0;
        unique case (w_action)
            RUN: ;
            LOAD_STALL: begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_bubble = 1'b1;
            end
            MEM_WAIT: begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_pipe_freeze  = 1'b1;
            end
            FLUSH: begin
                // IF_ID still loads, but the flush selects NOP_INSTR.
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_sb_idex     <= '0;
            r_sb_exmem    <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_action;
            if (!w_pc_write && (r_stall_count != '1))
                r_stall_count <= r_stall_count + CNT_ONE;
            // Freeze holds both slots; any other action advances the shadow
            // pipeline, with a bubble entering ID_EX unless IF_ID really moves.
            if (w_action != MEM_WAIT) begin
                r_sb_exmem <= r_sb_idex;
                r_sb_idex  <= ((w_action == RUN) && bus.IF_ID_valid) ? to_entry(w_dec) : NOP_ENTRY;
            end
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.IF_ID_write  = w_if_id_write;
    assign bus.IF_ID_flush  = w_if_id_flush;
    assign bus.ID_EX_bubble = w_id_ex_bubble;
    assign bus.pipe_freeze  = w_pipe_freeze;
    assign bus.state        = r_state;
    assign bus.stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit. A pipeline-occupancy model
// (which instruction sits in EX and MEM) predicts each cycle's controls;
// expectations are queued by the stimulus and popped by a monitor on the
// falling edge. A narrow counter makes saturation reachable.
module tb_hazard_stall_unit;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [4:0] OPC_LW   = 5'b10000;
    localparam logic [4:0] OPC_SW   = 5'b10001;
    localparam logic [4:0] OPC_ADD  = 5'b00000;
    localparam logic [4:0] OPC_ADDI = 5'b01000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.STALL_CNT_W(CW)) bus ();

    hazard_stall_unit #(.STALL_CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [4:0] pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
        int         state;
        int         cnt;
        string      tag;
    } exp_t;

    typedef struct {
        bit          valid;
        logic [18:0] ins;
    } stage_t;

    exp_t   exp_q[$];
    stage_t m_ex, m_mem;
    int     m_state = 0;
    int     m_cnt   = 0;
    int     checks  = 0;
    int     failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [18:0] mk(input logic [4:0] op, input int d, input int a, input int b);
        logic [18:0] w;
        w = {op, 3'(d), 3'(a), 3'(b), 5'($urandom_range(0, 31))};
        return w;
    endfunction

    function automatic bit is_load(input logic [18:0] ins);
        return ins[18:14] == OPC_LW;
    endfunction

    function automatic bit is_store(input logic [18:0] ins);
        return ins[18:14] == OPC_SW;
    endfunction

    // Does this instruction need register r as an operand in ID/EX?
    // Store data is excluded: it is only needed in MEM.
    function automatic bit needs_reg(input logic [18:0] ins, input logic [2:0] r);
        logic [4:0] op;
        bit alu, imm;
        op  = ins[18:14];
        alu = (op[4] == 1'b0);
        imm = (op[3] == 1'b1);
        if ((alu || is_load(ins) || is_store(ins)) && ins[10:8] == r) return 1;
        if (alu && !imm && ins[7:5] == r) return 1;
        return 0;
    endfunction

    // One pipeline cycle: drive, predict, queue, advance the model.
    task automatic cycle(input logic [18:0] ins, input bit v, input bit br,
                         input bit mr, input bit rn, input string tag);
        exp_t e;
        int   act;
        bit   lu, mw;
        @(posedge clk);
        #1;
        bus.IF_ID_instruction = ins;
        bus.IF_ID_valid       = v;
        bus.branch_taken_EX   = br;
        bus.mem_ready         = mr;
        rst_n                 = rn;

        mw = m_mem.valid && (is_load(m_mem.ins) || is_store(m_mem.ins)) && !mr;
        lu = m_ex.valid && is_load(m_ex.ins) && (m_ex.ins[13:11] != 3'd0) && v &&
             needs_reg(ins, m_ex.ins[13:11]);
        if (!rn)      act = 0;
        else if (mw)  act = 2;
        else if (br)  act = 3;
        else if (lu)  act = 1;
        else          act = 0;

        e.tag   = tag;
        e.state = m_state;
        e.cnt   = m_cnt;
        case (act)
            1:       begin e.pc_write = 0; e.if_id_write = 0; e.if_id_flush = 0; e.id_ex_bubble = 1; e.pipe_freeze = 0; end
            2:       begin e.pc_write = 0; e.if_id_write = 0; e.if_id_flush = 0; e.id_ex_bubble = 0; e.pipe_freeze = 1; end
            3:       begin e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 1; e.id_ex_bubble = 1; e.pipe_freeze = 0; end
            default: begin e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 0; e.id_ex_bubble = 0; e.pipe_freeze = 0; end
        endcase
        exp_q.push_back(e);

        if (!rn) begin
            m_ex    = '{valid: 0, ins: '0};
            m_mem   = '{valid: 0, ins: '0};
            m_state = 0;
            m_cnt   = 0;
        end else begin
            m_state = act;
            if ((act == 1 || act == 2) && m_cnt < CNT_MAX) m_cnt++;
            if (act != 2) begin
                m_mem       = m_ex;
                m_ex.valid  = (act == 0) && v;
                m_ex.ins    = ins;
            end
        end
    endtask

    task automatic do_reset();
        cycle(19'd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
    endtask

    // Monitor: compare every presented cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".pc_write"},     bus.pc_write,     e.pc_write);
                check({e.tag, ".IF_ID_write"},  bus.IF_ID_write,  e.if_id_write);
                check({e.tag, ".IF_ID_flush"},  bus.IF_ID_flush,  e.if_id_flush);
                check({e.tag, ".ID_EX_bubble"}, bus.ID_EX_bubble, e.id_ex_bubble);
                check({e.tag, ".pipe_freeze"},  bus.pipe_freeze,  e.pipe_freeze);
                check({e.tag, ".state"},        bus.state,        e.state);
                check({e.tag, ".stall_count"},  bus.stall_count,  e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_ex  = '{valid: 0, ins: '0};
        m_mem = '{valid: 0, ins: '0};
        bus.IF_ID_instruction = '0;
        bus.IF_ID_valid       = 1'b0;
        bus.branch_taken_EX   = 1'b0;
        bus.mem_ready         = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state
        do_reset();
        #1; check("reset_pc_write", bus.pc_write, 1);
        check("reset_freeze", bus.pipe_freeze, 0);

        // LW r3 ; ADD r1,r3,r2 -> one stall cycle
        cycle(mk(OPC_LW, 3, 2, 0), 1, 0, 1, 1, "lu_lw");
        cycle(mk(OPC_ADD, 1, 3, 2), 1, 0, 1, 1, "lu_add");
        #1; check("lu_pc_write", bus.pc_write, 0);
        check("lu_bubble", bus.ID_EX_bubble, 1);
        check("lu_cnt_before", bus.stall_count, 0);
        cycle(mk(OPC_ADD, 1, 3, 2), 1, 0, 1, 1, "lu_add2");
        #1; check("lu_pc_after", bus.pc_write, 1);
        check("lu_cnt_after", bus.stall_count, 1);
        check("lu_state", bus.state, 1);

        // Immediate ALU ignores B; r0 never stalls
        do_reset();
        cycle(mk(OPC_LW, 3, 2, 0), 1, 0, 1, 1, "imm_lw");
        cycle(mk(OPC_ADDI, 1, 2, 3), 1, 0, 1, 1, "imm_addi");
        #1; check("imm_no_stall", bus.pc_write, 1);
        do_reset();
        cycle(mk(OPC_LW, 0, 2, 0), 1, 0, 1, 1, "r0_lw");
        cycle(mk(OPC_ADD, 1, 0, 2), 1, 0, 1, 1, "r0_add");
        #1; check("r0_no_stall", bus.pc_write, 1);

        // Store data vs store address
        do_reset();
        cycle(mk(OPC_LW, 3, 2, 0), 1, 0, 1, 1, "swd_lw");
        cycle(mk(OPC_SW, 3, 2, 4), 1, 0, 1, 1, "swd_sw");
        #1; check("sw_data_no_stall", bus.pc_write, 1);
        do_reset();
        cycle(mk(OPC_LW, 3, 2, 0), 1, 0, 1, 1, "swa_lw");
        cycle(mk(OPC_SW, 1, 3, 4), 1, 0, 1, 1, "swa_sw");
        #1; check("sw_addr_stall", bus.pc_write, 0);

        // SW in EX_MEM, mem_ready low for 3 cycles
        do_reset();
        cycle(mk(OPC_SW, 1, 2, 0), 1, 0, 1, 1, "mw_sw");
        cycle(mk(OPC_ADD, 4, 5, 6), 1, 0, 1, 1, "mw_add");
        for (int i = 0; i < 3; i++) begin
            cycle(mk(OPC_ADD, 4, 5, 6), 1, 0, 0, 1, "mw_wait");
            #1; check("mw_freeze", bus.pipe_freeze, 1);
        end
        cycle(mk(OPC_ADD, 4, 5, 6), 1, 0, 1, 1, "mw_done");
        #1; check("mw_cnt", bus.stall_count, 3);
        check("mw_pc_resume", bus.pc_write, 1);

        // Branch coincident with load-use
        do_reset();
        cycle(mk(OPC_LW, 3, 2, 0), 1, 0, 1, 1, "br_lw");
        cycle(mk(OPC_ADD, 1, 3, 2), 1, 1, 1, 1, "br_flush");
        #1; check("br_flush", bus.IF_ID_flush, 1);
        check("br_pc_write", bus.pc_write, 1);
        cycle(mk(OPC_ADD, 1, 4, 5), 1, 0, 1, 1, "br_next");
        #1; check("br_cnt", bus.stall_count, 0);

        // Reset during MEM_WAIT
        do_reset();
        cycle(mk(OPC_SW, 1, 2, 0), 1, 0, 1, 1, "rmw_sw");
        cycle(mk(OPC_ADD, 4, 5, 6), 1, 0, 1, 1, "rmw_add");
        cycle(mk(OPC_ADD, 4, 5, 6), 1, 0, 0, 1, "rmw_wait");
        cycle(mk(OPC_ADD, 4, 5, 6), 1, 0, 0, 0, "rmw_rst");
        #1; check("rmw_rst_pc", bus.pc_write, 1);
        cycle(mk(OPC_ADD, 1, 3, 2), 1, 0, 0, 1, "rmw_after");
        #1; check("rmw_state", bus.state, 0);
        check("rmw_cnt", bus.stall_count, 0);
        check("rmw_pc", bus.pc_write, 1);

        // Counter saturation
        do_reset();
        cycle(mk(OPC_SW, 1, 2, 0), 1, 0, 1, 1, "sat_sw");
        cycle(mk(OPC_ADD, 4, 5, 6), 1, 0, 1, 1, "sat_add");
        for (int i = 0; i < CNT_MAX + 5; i++)
            cycle(mk(OPC_ADD, 4, 5, 6), 1, 0, 0, 1, "sat_wait");
        #1; check("sat_cnt", bus.stall_count, CNT_MAX);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] op;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 3)      op = OPC_LW;
            else if (sel < 5) op = OPC_SW;
            else if (sel < 7) op = {2'b00, 3'($urandom_range(0, 7))};
            else if (sel < 9) op = {2'b01, 3'($urandom_range(0, 7))};
            else              op = 5'($urandom_range(0, 31));
            cycle(mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0),
                  $sformatf("rand%0d", n));
        end

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage pipeline; the stall-side counterpart of the forwarding unit.
- The forwarding unit resolves dependencies that data paths can bypass. This block detects the ones they cannot: load-use, data-memory wait and taken branches.
- It drives PC/IF_ID write enables, bubble insertion and flushes.
- It keeps its own shadow scoreboard of ID_EX/EX_MEM destinations, so it needs only the IF_ID instruction plus status inputs.

Parameters:
- STALL_CNT_W, 16, width of saturating stall-cycle counter
- NOP_INSTR, 19'b0, instruction injected as a bubble (ALU op, dst r0)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous reset, active low
- IF_ID_instruction  in  19  decoded next; [18:14] op, [13:11] dst, [10:8] A, [7:5] B
- IF_ID_valid  in  1  IF_ID holds a real instruction
- branch_taken_EX  in  1  branch resolved taken in EX this cycle
- mem_ready  in  1  data memory completes the access in MEM this cycle
- pc_write  out  1  PC update enable
- IF_ID_write  out  1  IF_ID register load enable
- IF_ID_flush  out  1  load NOP_INSTR into IF_ID
- ID_EX_bubble  out  1  load NOP_INSTR into ID_EX
- pipe_freeze  out  1  hold ID_EX, EX_MEM, MEM_WB
- state  out  2  RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3
- stall_count  out  STALL_CNT_W  cycles with pc_write=0, saturating

Behaviour:
Reset (rst_n=0 at posedge):
- state=RUN, scoreboard cleared (all dst=0, all flags=0), stall_count=0.
- Outputs while in reset: pc_write=1, IF_ID_write=1, all other controls 0.

Decode rules:
- ALU: op[18]=0.
- imm: op[17]=1; B field is unused.
- LW: op=10000. SW: op=10001.
- SW store data is dst[13:11]; SW address is A.

Scoreboard:
- Entries sb_idex and sb_exmem, each holding {dst, is_lw, is_mem}.
- On an advancing cycle: sb_exmem<=sb_idex; sb_idex<=IF_ID fields, or zeros when a bubble is inserted or IF_ID_valid=0.
- On a freeze cycle: both entries hold.
- On a flush: sb_idex<=0.

Load-use hazard:
- Condition: sb_idex.is_lw, sb_idex.dst!=0, IF_ID_valid, and any of:
  - sb_idex.dst==A, for ALU, LW or SW;
  - sb_idex.dst==B, for a non-imm ALU op.
- LW -> SW data (dst match) does NOT stall; MEM forwarding handles it.

Memory wait:
- sb_exmem.is_mem && !mem_ready.

Priority each cycle, combinational in the current cycle:
1. branch_taken_EX -> FLUSH action: IF_ID_flush=1, ID_EX_bubble=1, pc_write=1 (target load), pipe_freeze=0. Overrides a pending load stall.
2. If the memory wait is also active, memory wait wins over branch: freeze everything, no flush. The branch is re-presented by the EX stage while frozen.
3. Memory wait -> MEM_WAIT action: pc_write=0, IF_ID_write=0, pipe_freeze=1, ID_EX_bubble=0.
4. Load-use -> LOAD_STALL action: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, pipe_freeze=0.
   - Exactly one stall cycle; the next cycle the LW is in EX_MEM and forwarding covers the dependency.
5. Otherwise RUN: pc_write=1, IF_ID_write=1, others 0.

FSM and counter:
- state registers the action taken in the previous cycle (a visibility/debug output; one cycle latency).
- stall_count increments on every cycle with pc_write=0 and saturates at all-ones.
- A MEM_WAIT lasting N cycles counts N. If a load-use is pending behind it, the LOAD_STALL follows after mem_ready and counts +1.
- Reset mid-stall aborts immediately; the next cycle is RUN with a cleared scoreboard.
- dst=r0 never causes a stall.
- IF_ID_valid=0 never stalls and inserts a bubble entry into the scoreboard.

Decomposition:
- Shared package pipe_pkg:
  - opcode constants OP_LW=5'b10000 and OP_SW=5'b10001;
  - field-slice localparams for dst, A and B;
  - NOP_INSTR;
  - a state enum for RUN, LOAD_STALL, MEM_WAIT and FLUSH.
  The forwarding unit uses the same package.
- One sub-module, instr_class_decode: a combinational 19-bit instruction -> {is_alu, is_imm, is_lw, is_sw, dst, A, B} decoder. Instantiate it for IF_ID.

Test Plan:
- LW r3 then ADD r1,r3,r2 -> 1 cycle pc_write=0, ID_EX_bubble=1; stall_count 0->1; next cycle RUN.
- LW r3 then ADDI r1,r2,#5 with B field=3 -> no stall; also LW r0 then ADD r1,r0,r2 -> no stall.
- LW r3 then SW r3,4(r2) -> no stall; LW r3 then SW r1,4(r3) -> 1-cycle stall.
- SW in EX_MEM with mem_ready low for 3 cycles -> pipe_freeze=1 and pc_write=0 for 3 cycles, scoreboard held, stall_count=3.
- branch_taken_EX coincident with a load-use hazard -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, no stall; stall_count unchanged.
- rst_n low during MEM_WAIT -> next cycle state=RUN, stall_count=0, pc_write=1, a following ADD with no real producer does not stall.
